// File: rtl/pipe_sortn_stream_if.sv
// Stream bundle for pipe_sortn_stream: input vector handshake, output vector handshake,
// and the optional original-index lanes. master = producer/consumer side, slave = sorter side.
interface pipe_sortn_stream_if #(
  parameter int DW = 3,
  parameter int N  = 4
);
  localparam int IW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic            in_desc;
  logic [N*DW-1:0] inp;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] outp;
  logic [N*IW-1:0] outp_idx;

  modport master (
    output in_valid, in_desc, inp, out_ready,
    input  in_ready, out_valid, outp, outp_idx
  );

  modport slave (
    input  in_valid, in_desc, inp, out_ready,
    output in_ready, out_valid, outp, outp_idx
  );
endinterface

// File: rtl/pipe_sortn_stream.sv
// Streaming odd-even transposition sorter: N registered compare-exchange stages, one vector per cycle.
// Define SORT_INDEX_EN to carry per-lane original-index tags; otherwise outp_idx is tied to 0.
module pipe_sortn_stream #(
  parameter int DW = 3,
  parameter int N  = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipe_sortn_stream_if.slave bus
);
  typedef logic [N-1:0][DW-1:0] lanes_t;
`ifdef SORT_INDEX_EN
  localparam int IW = $clog2(N);
  typedef logic [N-1:0][IW-1:0] tags_t;
`endif

  // Handshake: a vector enters on in_valid && in_ready and leaves on out_valid && out_ready.
  // All stages share one enable, so the only stall source is an unaccepted output slot.
  logic         en;
  logic [N-1:0] vld_q;
  logic [N-2:0] desc_q;
  lanes_t       dat_q [N];
  lanes_t       dat_d [N];
`ifdef SORT_INDEX_EN
  tags_t        idx_q [N];
  tags_t        idx_d [N];
`endif

  assign en            = !(vld_q[N-1] && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[N-1];
  assign bus.outp      = dat_q[N-1];
`ifdef SORT_INDEX_EN
  assign bus.outp_idx  = idx_q[N-1];
`else
  assign bus.outp_idx  = '0;
`endif

  for (genvar s = 0; s < N; s++) begin : g_stage
    lanes_t src_dat;
    lanes_t nxt_dat;
    logic   src_desc;
`ifdef SORT_INDEX_EN
    tags_t  src_idx;
    tags_t  nxt_idx;
`endif

    if (s == 0) begin : g_src
      assign src_dat  = bus.inp;
      assign src_desc = bus.in_desc;
`ifdef SORT_INDEX_EN
      always_comb begin
        src_idx = '0;
        for (int k = 0; k < N; k++) begin
          src_idx[k] = IW'(k);
        end
      end
`endif
    end else begin : g_src
      assign src_dat  = dat_q[s-1];
      assign src_desc = desc_q[s-1];
`ifdef SORT_INDEX_EN
      assign src_idx  = idx_q[s-1];
`endif
    end

    // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...; strict compare keeps ties in order.
    always_comb begin
      nxt_dat = src_dat;
`ifdef SORT_INDEX_EN
      nxt_idx = src_idx;
`endif
      for (int j = s % 2; j < N - 1; j += 2) begin
        if (src_desc ? (src_dat[j] < src_dat[j+1]) : (src_dat[j] > src_dat[j+1])) begin
          nxt_dat[j]   = src_dat[j+1];
          nxt_dat[j+1] = src_dat[j];
`ifdef SORT_INDEX_EN
          nxt_idx[j]   = src_idx[j+1];
          nxt_idx[j+1] = src_idx[j];
`endif
        end
      end
    end

    assign dat_d[s] = nxt_dat;
`ifdef SORT_INDEX_EN
    assign idx_d[s] = nxt_idx;
`endif
  end

  // The last stage needs no mode bit: nothing is compared after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      desc_q <= '0;
      for (int s = 0; s < N; s++) begin
        dat_q[s] <= '0;
`ifdef SORT_INDEX_EN
        idx_q[s] <= '0;
`endif
      end
    end else if (en) begin
      vld_q     <= {vld_q[N-2:0], bus.in_valid};
      desc_q[0] <= bus.in_desc;
      for (int s = 1; s < N - 1; s++) begin
        desc_q[s] <= desc_q[s-1];
      end
      for (int s = 0; s < N; s++) begin
        dat_q[s] <= dat_d[s];
`ifdef SORT_INDEX_EN
        idx_q[s] <= idx_d[s];
`endif
      end
    end
  end
endmodule
